// File: rtl/alu_operand_loader.sv
// Assembles an {op, a, b} ALU command from three strobed byte writes and offers it on a
// valid/ready handshake. Optional mid-frame idle timeout: define OPLOAD_TIMEOUT_EN.
module alu_operand_loader #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       strobe_in,
  input  logic       abort,
  output logic [2:0] op,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic       op_valid,
  input  logic       op_ready,
  output logic [1:0] phase,
  output logic [1:0] err
);

  typedef enum logic [1:0] {
    StWaitOp = 2'd0,
    StWaitA  = 2'd1,
    StWaitB  = 2'd2,
    StIssue  = 2'd3
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   strobe_edge;
  logic                   overrun_q;
  logic                   timeout_q;
  logic                   idle_expired;

  // Strobe is asynchronous: resynchronise, then detect the rising edge one flop later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign strobe_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

`ifdef OPLOAD_TIMEOUT_EN
  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

  logic [7:0] idle_q;
  logic       mid_frame;

  assign mid_frame    = (state_q == StWaitA) || (state_q == StWaitB);
  assign idle_expired = mid_frame && !strobe_edge && ((idle_q + 8'd1) == TimeoutLimit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= 8'd0;
    end else if (abort || strobe_edge || idle_expired || !mid_frame) begin
      idle_q <= 8'd0;
    end else begin
      idle_q <= idle_q + 8'd1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign idle_expired       = 1'b0;
`endif

  // abort has priority over everything, including a pending transfer and a strobe edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StWaitOp;
      op        <= 3'd0;
      a         <= 8'd0;
      b         <= 8'd0;
      op_valid  <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else if (abort) begin
      state_q   <= StWaitOp;
      op_valid  <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StWaitOp: begin
          if (strobe_edge) begin
            op      <= data_in[7:5];
            state_q <= StWaitA;
          end
        end
        StWaitA: begin
          if (strobe_edge) begin
            a       <= data_in;
            state_q <= StWaitB;
          end else if (idle_expired) begin
            state_q   <= StWaitOp;
            timeout_q <= 1'b1;
          end
        end
        StWaitB: begin
          if (strobe_edge) begin
            b        <= data_in;
            state_q  <= StIssue;
            op_valid <= 1'b1;
          end else if (idle_expired) begin
            state_q   <= StWaitOp;
            timeout_q <= 1'b1;
          end
        end
        StIssue: begin
          // A byte arriving here is dropped; the waiting command is left untouched.
          if (strobe_edge) begin
            overrun_q <= 1'b1;
          end
          if (op_ready) begin
            state_q  <= StWaitOp;
            op_valid <= 1'b0;
          end
        end
        default: begin
          state_q  <= StWaitOp;
          op_valid <= 1'b0;
        end
      endcase
    end
  end

  assign phase = state_q;
  assign err   = {timeout_q, overrun_q};

endmodule
